// File: rtl/ct_idu_is_aiq_lch_sel_if.sv
//------------------------------------------------------------------------------
// ct_idu_is_aiq_lch_sel_if
//
// Purpose:
//   Bundles the signals between the AIQ entry array / RF stage and the AIQ
//   launch selector.
//
// Signals:
//   rtu_flush        pipeline flush
//   x_entry_vld      per-entry valid
//   x_entry_lch_rdy  per-entry launch ready, entry i at [2i+1:2i]
//                    (bit0 = pipe0, bit1 = pipe1)
//   x_create0_en     create port 0 write enable
//   x_create0_entry  create port 0 one-hot target entry
//   x_create1_en     create port 1 write enable
//   x_create1_entry  create port 1 one-hot target entry
//   x_pop_entry      entries freed after a successful launch
//   x_cancel_entry   launched entries that are cancelled/replayed
//   pipe0_stall      pipe0 RF stage cannot accept
//   pipe1_stall      pipe1 RF stage cannot accept
//   lch0_vld         registered pipe0 launch valid
//   lch0_entry       registered one-hot pipe0 launch entry
//   lch1_vld         registered pipe1 launch valid
//   lch1_entry       registered one-hot pipe1 launch entry
//   x_frz            frozen (in-flight) entry mask
//
// Modports:
//   master : the issue-queue / pipeline side driving the selector
//   slave  : the launch selector itself
//------------------------------------------------------------------------------
interface ct_idu_is_aiq_lch_sel_if #(
    parameter int ENTRY = 8
);
    logic                   rtu_flush;
    logic [ENTRY-1:0]       x_entry_vld;
    logic [2*ENTRY-1:0]     x_entry_lch_rdy;
    logic                   x_create0_en;
    logic [ENTRY-1:0]       x_create0_entry;
    logic                   x_create1_en;
    logic [ENTRY-1:0]       x_create1_entry;
    logic [ENTRY-1:0]       x_pop_entry;
    logic [ENTRY-1:0]       x_cancel_entry;
    logic                   pipe0_stall;
    logic                   pipe1_stall;
    logic                   lch0_vld;
    logic [ENTRY-1:0]       lch0_entry;
    logic                   lch1_vld;
    logic [ENTRY-1:0]       lch1_entry;
    logic [ENTRY-1:0]       x_frz;

    modport master (
        output rtu_flush,
        output x_entry_vld,
        output x_entry_lch_rdy,
        output x_create0_en,
        output x_create0_entry,
        output x_create1_en,
        output x_create1_entry,
        output x_pop_entry,
        output x_cancel_entry,
        output pipe0_stall,
        output pipe1_stall,
        input  lch0_vld,
        input  lch0_entry,
        input  lch1_vld,
        input  lch1_entry,
        input  x_frz
    );

    modport slave (
        input  rtu_flush,
        input  x_entry_vld,
        input  x_entry_lch_rdy,
        input  x_create0_en,
        input  x_create0_entry,
        input  x_create1_en,
        input  x_create1_entry,
        input  x_pop_entry,
        input  x_cancel_entry,
        input  pipe0_stall,
        input  pipe1_stall,
        output lch0_vld,
        output lch0_entry,
        output lch1_vld,
        output lch1_entry,
        output x_frz
    );
endinterface

// File: rtl/ct_idu_is_aiq_lch_sel.sv
//------------------------------------------------------------------------------
// ct_idu_is_aiq_lch_sel
//
// Purpose:
//   Launch selector for one arithmetic issue queue. Each cycle it picks the
//   oldest ready, non-frozen entry for pipe0 and, from the remaining entries,
//   the oldest ready entry for pipe1. Relative age is held in an age matrix
//   updated on entry creation. Selected entries are frozen until popped,
//   cancelled or flushed, and the picks are registered as one-hot launch
//   selects towards the IS->RF stage.
//
// Ports:
//   y_clk     clock
//   cpurst_b  asynchronous active-low reset
//   aiq_if    ct_idu_is_aiq_lch_sel_if.slave (see interface for signal list)
//------------------------------------------------------------------------------
module ct_idu_is_aiq_lch_sel #(
    parameter int ENTRY = 8
) (
    input logic                     y_clk,
    input logic                     cpurst_b,
    ct_idu_is_aiq_lch_sel_if.slave  aiq_if
);

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    // age_q[i][j] = 1 : entry i is older than entry j
    logic [ENTRY-1:0][ENTRY-1:0] age_q;
    logic [ENTRY-1:0][ENTRY-1:0] age_d;
    logic [ENTRY-1:0]            frz_q;
    logic [ENTRY-1:0]            frz_d;
    logic                        lch0_vld_q;
    logic                        lch0_vld_d;
    logic [ENTRY-1:0]            lch0_entry_q;
    logic [ENTRY-1:0]            lch0_entry_d;
    logic                        lch1_vld_q;
    logic                        lch1_vld_d;
    logic [ENTRY-1:0]            lch1_entry_q;
    logic [ENTRY-1:0]            lch1_entry_d;

    //--------------------------------------------------------------------------
    // Combinational intermediates
    //--------------------------------------------------------------------------
    logic [ENTRY-1:0] cre0_w;
    logic [ENTRY-1:0] cre1_w;
    logic [ENTRY-1:0] cre_w;
    logic [ENTRY-1:0] rdy0_w;
    logic [ENTRY-1:0] rdy1_w;
    logic [ENTRY-1:0] cand0_w;
    logic [ENTRY-1:0] cand1_w;
    logic             hold0_w;
    logic             hold1_w;
    logic [ENTRY-1:0] sel0_w;
    logic [ENTRY-1:0] sel1_w;
    logic [ENTRY-1:0] clr_w;

    //--------------------------------------------------------------------------
    // Oldest-entry picker.
    // An entry wins when no other candidate is marked older than it. With a
    // consistent age matrix exactly one candidate wins; the lowest-index
    // isolation below keeps the result one-hot even if the matrix were ever
    // inconsistent (e.g. entries marked valid without passing a create port),
    // and falls back to the lowest-index candidate if no entry qualifies.
    //--------------------------------------------------------------------------
    function automatic logic [ENTRY-1:0] f_oldest(
        input logic [ENTRY-1:0]            cand,
        input logic [ENTRY-1:0][ENTRY-1:0] age
    );
        logic [ENTRY-1:0] win;
        logic [ENTRY-1:0] pick;
        logic             found;
        win   = cand;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < ENTRY; i++) begin
            for (int j = 0; j < ENTRY; j++) begin
                if ((j != i) && cand[j] && age[j][i]) begin
                    win[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < ENTRY; i++) begin
            if (win[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < ENTRY; i++) begin
            if (cand[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

    //--------------------------------------------------------------------------
    // Create masks and per-pipe ready split
    //--------------------------------------------------------------------------
    assign cre0_w = aiq_if.x_create0_en ? aiq_if.x_create0_entry : '0;
    assign cre1_w = aiq_if.x_create1_en ? aiq_if.x_create1_entry : '0;
    assign cre_w  = cre0_w | cre1_w;

    always_comb begin
        rdy0_w = '0;
        rdy1_w = '0;
        for (int i = 0; i < ENTRY; i++) begin
            rdy0_w[i] = aiq_if.x_entry_lch_rdy[2*i];
            rdy1_w[i] = aiq_if.x_entry_lch_rdy[2*i+1];
        end
    end

    // An entry being written this cycle carries stale ready/valid state, so it
    // is kept out of selection until the following cycle.
    assign cand0_w = aiq_if.x_entry_vld & rdy0_w & ~frz_q & ~cre_w;
    assign cand1_w = aiq_if.x_entry_vld & rdy1_w & ~frz_q & ~cre_w;

    //--------------------------------------------------------------------------
    // Selection. A pipe that is stalled while holding a launch makes no new
    // pick, so pipe1 may then take the oldest entry if it is pipe1-ready.
    //--------------------------------------------------------------------------
    assign hold0_w = aiq_if.pipe0_stall & lch0_vld_q;
    assign hold1_w = aiq_if.pipe1_stall & lch1_vld_q;

    assign sel0_w = hold0_w ? '0 : f_oldest(cand0_w, age_q);
    assign sel1_w = hold1_w ? '0 : f_oldest(cand1_w & ~sel0_w, age_q);

    //--------------------------------------------------------------------------
    // Launch register next state
    //--------------------------------------------------------------------------
    always_comb begin
        lch0_vld_d   = lch0_vld_q;
        lch0_entry_d = lch0_entry_q;
        lch1_vld_d   = lch1_vld_q;
        lch1_entry_d = lch1_entry_q;
        if (aiq_if.rtu_flush) begin
            lch0_vld_d   = 1'b0;
            lch0_entry_d = '0;
            lch1_vld_d   = 1'b0;
            lch1_entry_d = '0;
        end else begin
            if (!hold0_w) begin
                lch0_vld_d   = |sel0_w;
                lch0_entry_d = sel0_w;
            end
            if (!hold1_w) begin
                lch1_vld_d   = |sel1_w;
                lch1_entry_d = sel1_w;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Freeze next state: clear (pop/cancel/flush) wins over a same-cycle set.
    // Held pipes contribute an all-zero select, so no extra gating is needed.
    //--------------------------------------------------------------------------
    assign clr_w = aiq_if.x_pop_entry | aiq_if.x_cancel_entry
                 | {ENTRY{aiq_if.rtu_flush}};
    assign frz_d = (frz_q | sel0_w | sel1_w) & ~clr_w;

    //--------------------------------------------------------------------------
    // Age matrix next state.
    // A created entry becomes younger than every surviving valid entry: its
    // row is cleared and its column takes the current valid mask (excluding
    // other entries created this cycle). For a dual create, create0 is older.
    //--------------------------------------------------------------------------
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < ENTRY; i++) begin
            for (int j = 0; j < ENTRY; j++) begin
                if (i == j) begin
                    age_d[i][j] = 1'b0;
                end else if (cre_w[i]) begin
                    age_d[i][j] = cre0_w[i] & cre1_w[j];
                end else if (cre_w[j]) begin
                    age_d[i][j] = aiq_if.x_entry_vld[i];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge y_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            age_q        <= '0;
            frz_q        <= '0;
            lch0_vld_q   <= 1'b0;
            lch0_entry_q <= '0;
            lch1_vld_q   <= 1'b0;
            lch1_entry_q <= '0;
        end else begin
            age_q        <= age_d;
            frz_q        <= frz_d;
            lch0_vld_q   <= lch0_vld_d;
            lch0_entry_q <= lch0_entry_d;
            lch1_vld_q   <= lch1_vld_d;
            lch1_entry_q <= lch1_entry_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign aiq_if.lch0_vld   = lch0_vld_q;
    assign aiq_if.lch0_entry = lch0_entry_q;
    assign aiq_if.lch1_vld   = lch1_vld_q;
    assign aiq_if.lch1_entry = lch1_entry_q;
    assign aiq_if.x_frz      = frz_q;

endmodule

// File: tb/tb_ct_idu_is_aiq_lch_sel.sv
//------------------------------------------------------------------------------
// tb_ct_idu_is_aiq_lch_sel
//
// Purpose:
//   Self-checking bench for the AIQ launch selector: directed scenarios plus a
//   randomized run checked against a timestamp-based reference model.
//------------------------------------------------------------------------------
module tb_ct_idu_is_aiq_lch_sel;

    localparam int N = 8;

    logic y_clk;
    logic cpurst_b;

    int n_chk;
    int n_fail;

    ct_idu_is_aiq_lch_sel_if #(.ENTRY(N)) bus ();

    ct_idu_is_aiq_lch_sel #(.ENTRY(N)) dut (
        .y_clk    (y_clk),
        .cpurst_b (cpurst_b),
        .aiq_if   (bus.slave)
    );

    initial y_clk = 1'b0;
    always #5 y_clk = ~y_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state: an entry's age is its creation sequence number.
    logic [N-1:0] m_vld;
    logic [N-1:0] m_frz;
    logic         m_l0v;
    logic [N-1:0] m_l0e;
    logic         m_l1v;
    logic [N-1:0] m_l1e;
    int           m_seq [N];
    int           m_next_seq;

    //--------------------------------------------------------------------------
    // Utilities (stimulus only)
    //--------------------------------------------------------------------------
    task automatic tick();
        @(posedge y_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rtu_flush       = 1'b0;
        bus.x_entry_vld     = '0;
        bus.x_entry_lch_rdy = '0;
        bus.x_create0_en    = 1'b0;
        bus.x_create0_entry = '0;
        bus.x_create1_en    = 1'b0;
        bus.x_create1_entry = '0;
        bus.x_pop_entry     = '0;
        bus.x_cancel_entry  = '0;
        bus.pipe0_stall     = 1'b0;
        bus.pipe1_stall     = 1'b0;
    endtask

    task automatic do_reset();
        cpurst_b = 1'b0;
        clear_inputs();
        repeat (2) @(posedge y_clk);
        #1;
        cpurst_b = 1'b1;
    endtask

    function automatic logic [2*N-1:0] mk_rdy(input logic [N-1:0] p0,
                                              input logic [N-1:0] p1);
        logic [2*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[2*i]   = p0[i];
            r[2*i+1] = p1[i];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    // Model: oldest candidate = smallest creation sequence number.
    function automatic int m_oldest(input logic [N-1:0] cand);
        int best;
        best = -1;
        for (int i = 0; i < N; i++) begin
            if (cand[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        end
        return best;
    endfunction

    function automatic int rand_free(input logic [N-1:0] f);
        int start;
        int k;
        start = $urandom_range(0, N-1);
        for (int n = 0; n < N; n++) begin
            k = (start + n) % N;
            if (f[k]) return k;
        end
        return -1;
    endfunction

    //--------------------------------------------------------------------------
    // Tests
    //--------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_chk++;
        if (bus.lch0_vld !== 1'b0 || bus.lch1_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vld: got %b/%b expected 0/0", bus.lch0_vld, bus.lch1_vld);
        end
        n_chk++;
        if (bus.lch0_entry !== 8'h00 || bus.lch1_entry !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_entry: got %h/%h expected 00/00", bus.lch0_entry, bus.lch1_entry);
        end
        n_chk++;
        if (bus.x_frz !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_frz: got %h expected 00", bus.x_frz);
        end
        // All entries invalid while every ready bit is high.
        bus.x_entry_lch_rdy = '1;
        tick();
        n_chk++;
        if (bus.lch0_vld !== 1'b0 || bus.lch1_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL all_invalid: got %b/%b expected 0/0", bus.lch0_vld, bus.lch1_vld);
        end
    endtask

    task automatic test_age_order();
        do_reset();
        bus.x_create0_en = 1'b1; bus.x_create0_entry = 8'b0000_1000; tick();
        bus.x_entry_vld = 8'b0000_1000;
        bus.x_create0_entry = 8'b0010_0000; tick();
        bus.x_entry_vld = 8'b0010_1000;
        bus.x_create0_entry = 8'b0000_0010; tick();
        bus.x_create0_en = 1'b0; bus.x_create0_entry = '0;
        bus.x_entry_vld = 8'b0010_1010;
        bus.x_entry_lch_rdy = mk_rdy(8'b0010_1010, 8'h00);
        tick();
        n_chk++;
        if (bus.lch0_vld !== 1'b1 || bus.lch0_entry !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL age_first: got %b/%b expected 1/00001000", bus.lch0_vld, bus.lch0_entry);
        end
        n_chk++;
        if (bus.lch1_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL age_pipe1_idle: got %b expected 0", bus.lch1_vld);
        end
        tick();
        n_chk++;
        if (bus.lch0_entry !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL age_second: got %b expected 00100000", bus.lch0_entry);
        end
        n_chk++;
        if (bus.x_frz !== 8'b0010_1000) begin
            n_fail++;
            $display("FAIL age_frz: got %b expected 00101000", bus.x_frz);
        end
        tick();
        n_chk++;
        if (bus.lch0_entry !== 8'b0000_0010) begin
            n_fail++;
            $display("FAIL age_third: got %b expected 00000010", bus.lch0_entry);
        end
    endtask

    task automatic test_dual_create();
        do_reset();
        bus.x_create0_en = 1'b1; bus.x_create0_entry = 8'b0000_0100;
        bus.x_create1_en = 1'b1; bus.x_create1_entry = 8'b0100_0000;
        tick();
        clear_inputs();
        bus.x_entry_vld = 8'b0100_0100;
        bus.x_entry_lch_rdy = mk_rdy(8'b0100_0100, 8'b0100_0100);
        tick();
        n_chk++;
        if (bus.lch0_entry !== 8'b0000_0100 || bus.lch1_entry !== 8'b0100_0000) begin
            n_fail++;
            $display("FAIL dual_sel: got %b/%b expected 00000100/01000000", bus.lch0_entry, bus.lch1_entry);
        end
        n_chk++;
        if (bus.x_frz !== 8'b0100_0100) begin
            n_fail++;
            $display("FAIL dual_frz: got %b expected 01000100", bus.x_frz);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.x_create0_en = 1'b1; bus.x_create0_entry = 8'b0001_0000; tick();
        bus.x_entry_vld = 8'b0001_0000;
        bus.x_create0_entry = 8'b1000_0000; tick();
        bus.x_create0_en = 1'b0; bus.x_create0_entry = '0;
        bus.x_entry_vld = 8'b1001_0000;
        bus.x_entry_lch_rdy = mk_rdy(8'b0001_0000, 8'h00);
        tick();
        n_chk++;
        if (bus.lch0_vld !== 1'b1 || bus.lch0_entry !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL stall_pre: got %b/%b expected 1/00010000", bus.lch0_vld, bus.lch0_entry);
        end
        bus.pipe0_stall = 1'b1;
        bus.x_entry_lch_rdy = mk_rdy(8'b0001_0000, 8'b1000_0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (bus.lch0_vld !== 1'b1 || bus.lch0_entry !== 8'b0001_0000) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %b/%b expected 1/00010000", k, bus.lch0_vld, bus.lch0_entry);
            end
            if (k == 0) begin
                n_chk++;
                if (bus.lch1_vld !== 1'b1 || bus.lch1_entry !== 8'b1000_0000) begin
                    n_fail++;
                    $display("FAIL stall_pipe1: got %b/%b expected 1/10000000", bus.lch1_vld, bus.lch1_entry);
                end
            end
        end
    endtask

    task automatic test_cancel();
        do_reset();
        bus.x_create0_en = 1'b1; bus.x_create0_entry = 8'b0000_0100; tick();
        bus.x_create0_en = 1'b0; bus.x_create0_entry = '0;
        bus.x_entry_vld = 8'b0000_0100;
        // Single entry ready on both pipes: pipe0 only.
        bus.x_entry_lch_rdy = mk_rdy(8'b0000_0100, 8'b0000_0100);
        tick();
        n_chk++;
        if (bus.lch0_entry !== 8'b0000_0100 || bus.lch1_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_both: got %b/%b expected 00000100/0", bus.lch0_entry, bus.lch1_vld);
        end
        bus.x_cancel_entry = 8'b0000_0100;
        tick();
        n_chk++;
        if (bus.x_frz !== 8'h00 || bus.lch0_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_clr: got frz=%b vld=%b expected 00000000/0", bus.x_frz, bus.lch0_vld);
        end
        bus.x_cancel_entry = '0;
        tick();
        n_chk++;
        if (bus.lch0_vld !== 1'b1 || bus.lch0_entry !== 8'b0000_0100 || bus.x_frz !== 8'b0000_0100) begin
            n_fail++;
            $display("FAIL cancel_resel: got %b/%b frz=%b expected 1/00000100/00000100", bus.lch0_vld, bus.lch0_entry, bus.x_frz);
        end
    endtask

    task automatic test_flush();
        logic [N-1:0] v;
        do_reset();
        v = '0;
        for (int k = 0; k < 4; k++) begin
            bus.x_entry_vld     = v;
            bus.x_create0_en    = 1'b1; bus.x_create0_entry = onehot(2*k);
            bus.x_create1_en    = 1'b1; bus.x_create1_entry = onehot(2*k+1);
            tick();
            v = v | onehot(2*k) | onehot(2*k+1);
        end
        clear_inputs();
        bus.x_entry_vld = v;
        bus.x_entry_lch_rdy = '1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++;
            if (bus.lch0_entry !== onehot(2*k) || bus.lch1_entry !== onehot(2*k+1)) begin
                n_fail++;
                $display("FAIL flush_fill[%0d]: got %b/%b expected %b/%b", k, bus.lch0_entry, bus.lch1_entry, onehot(2*k), onehot(2*k+1));
            end
        end
        n_chk++;
        if (bus.x_frz !== 8'hFF || bus.lch0_vld !== 1'b1 || bus.lch1_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got frz=%h vld=%b%b expected ff/11", bus.x_frz, bus.lch0_vld, bus.lch1_vld);
        end
        bus.rtu_flush = 1'b1;
        tick();
        bus.rtu_flush = 1'b0;
        n_chk++;
        if (bus.x_frz !== 8'h00 || bus.lch0_vld !== 1'b0 || bus.lch1_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clr: got frz=%h vld=%b%b expected 00/00", bus.x_frz, bus.lch0_vld, bus.lch1_vld);
        end
    endtask

    task automatic test_reset_midlaunch();
        do_reset();
        bus.x_create0_en = 1'b1; bus.x_create0_entry = 8'b0010_0000; tick();
        bus.x_create0_en = 1'b0; bus.x_create0_entry = '0;
        bus.x_entry_vld = 8'b0010_0000;
        bus.x_entry_lch_rdy = mk_rdy(8'h00, 8'b0010_0000);
        tick();
        n_chk++;
        if (bus.lch1_vld !== 1'b1 || bus.lch1_entry !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL rst_pre: got %b/%b expected 1/00100000", bus.lch1_vld, bus.lch1_entry);
        end
        #1;
        cpurst_b = 1'b0;
        #1;
        n_chk++;
        if (bus.lch1_vld !== 1'b0 || bus.lch1_entry !== 8'h00 || bus.x_frz !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async: got %b/%b frz=%h expected 0/00000000/00", bus.lch1_vld, bus.lch1_entry, bus.x_frz);
        end
        clear_inputs();
        @(posedge y_clk);
        #1;
        cpurst_b = 1'b1;
        bus.x_create0_en = 1'b1; bus.x_create0_entry = 8'b0000_1000; tick();
        bus.x_create0_en = 1'b0; bus.x_create0_entry = '0;
        bus.x_entry_vld = 8'b0000_1000;
        bus.x_entry_lch_rdy = mk_rdy(8'b0000_1000, 8'b0000_1000);
        tick();
        n_chk++;
        if (bus.lch0_vld !== 1'b1 || bus.lch0_entry !== 8'b0000_1000) begin
            n_fail++;
            $display("FAIL rst_after: got %b/%b expected 1/00001000", bus.lch0_vld, bus.lch0_entry);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]   pop, can, cre0, cre1, rdy0, rdy1, cand0, cand1;
        logic [2*N-1:0] rdy;
        bit             fl, s0, s1, st0, st1;
        int             p0, p1, i0, i1;
        do_reset();
        m_vld = '0; m_frz = '0;
        m_l0v = 1'b0; m_l0e = '0; m_l1v = 1'b0; m_l1e = '0;
        m_next_seq = 0;
        for (int i = 0; i < N; i++) m_seq[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            fl = ($urandom_range(0, 39) == 0);
            s0 = ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 3) == 0);
            pop = '0; can = '0;
            for (int i = 0; i < N; i++) begin
                if (m_frz[i]) begin
                    if ($urandom_range(0, 3) == 0) pop[i] = 1'b1;
                    else if ($urandom_range(0, 7) == 0) can[i] = 1'b1;
                end
            end
            i0 = -1; i1 = -1;
            if (!fl && $urandom_range(0, 1) == 1) i0 = rand_free(~m_vld);
            if (!fl && $urandom_range(0, 1) == 1) i1 = rand_free(~m_vld & ~onehot(i0));
            cre0 = onehot(i0);
            cre1 = onehot(i1);
            rdy = 16'($urandom);
            bus.rtu_flush       = fl;
            bus.x_entry_vld     = m_vld;
            bus.x_entry_lch_rdy = rdy;
            bus.x_create0_en    = (i0 >= 0);
            bus.x_create0_entry = cre0;
            bus.x_create1_en    = (i1 >= 0);
            bus.x_create1_entry = cre1;
            bus.x_pop_entry     = pop;
            bus.x_cancel_entry  = can;
            bus.pipe0_stall     = s0;
            bus.pipe1_stall     = s1;
            // Reference model
            for (int i = 0; i < N; i++) begin
                rdy0[i] = rdy[2*i];
                rdy1[i] = rdy[2*i+1];
            end
            st0 = s0 && m_l0v;
            st1 = s1 && m_l1v;
            cand0 = m_vld & rdy0 & ~m_frz & ~(cre0 | cre1);
            cand1 = m_vld & rdy1 & ~m_frz & ~(cre0 | cre1);
            p0 = st0 ? -1 : m_oldest(cand0);
            if (p0 >= 0) cand1[p0] = 1'b0;
            p1 = st1 ? -1 : m_oldest(cand1);
            if (fl) begin
                m_l0v = 1'b0; m_l0e = '0; m_l1v = 1'b0; m_l1e = '0;
            end else begin
                if (!st0) begin m_l0v = (p0 >= 0); m_l0e = onehot(p0); end
                if (!st1) begin m_l1v = (p1 >= 0); m_l1e = onehot(p1); end
            end
            for (int i = 0; i < N; i++) begin
                if (pop[i] || can[i] || fl) m_frz[i] = 1'b0;
                else if (i == p0 || i == p1) m_frz[i] = 1'b1;
            end
            if (i0 >= 0) begin m_seq[i0] = m_next_seq; m_next_seq++; end
            if (i1 >= 0) begin m_seq[i1] = m_next_seq; m_next_seq++; end
            m_vld = fl ? '0 : ((m_vld & ~pop) | cre0 | cre1);
            tick();
            n_chk++;
            if (bus.lch0_vld !== m_l0v || bus.lch0_entry !== m_l0e) begin
                n_fail++;
                $display("FAIL rand_lch0 cyc %0d: got %b/%b expected %b/%b", cyc, bus.lch0_vld, bus.lch0_entry, m_l0v, m_l0e);
            end
            n_chk++;
            if (bus.lch1_vld !== m_l1v || bus.lch1_entry !== m_l1e) begin
                n_fail++;
                $display("FAIL rand_lch1 cyc %0d: got %b/%b expected %b/%b", cyc, bus.lch1_vld, bus.lch1_entry, m_l1v, m_l1e);
            end
            n_chk++;
            if (bus.x_frz !== m_frz) begin
                n_fail++;
                $display("FAIL rand_frz cyc %0d: got %b expected %b", cyc, bus.x_frz, m_frz);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cpurst_b = 1'b0;
        clear_inputs();
        test_reset();
        test_age_order();
        test_dual_create();
        test_stall();
        test_cancel();
        test_flush();
        test_reset_midlaunch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_idu_is_aiq_lch_sel.md
Name: ct_idu_is_aiq_lch_sel

Overview:
Launch selector for one arithmetic issue queue (AIQ), directly downstream of the per-entry launch-ready registers.
- Consumes each entry's 2-bit launch-ready vector (bit0 = pipe0, bit1 = pipe1) and picks the oldest ready entry for each of the two launch pipes.
- Tracks relative entry age in an age matrix and freezes selected entries until they are popped or cancelled.
- Drives registered one-hot launch selects to the IS→RF stage.

Parameters:
ENTRY, 8, number of AIQ entries (one-hot width of entry vectors)

Ports:
y_clk  in  1  clock
cpurst_b  in  1  asynchronous active-low reset
rtu_flush  in  1  pipeline flush
x_entry_vld  in  ENTRY  entry valid, from the AIQ entry array
x_entry_lch_rdy  in  2*ENTRY  entry i uses bits [2i+1:2i]; bit0 = pipe0 ready, bit1 = pipe1 ready
x_create0_en  in  1  create port 0 writes an entry this cycle
x_create0_entry  in  ENTRY  one-hot create-0 target
x_create1_en  in  1  create port 1 writes an entry this cycle
x_create1_entry  in  ENTRY  one-hot create-1 target
x_pop_entry  in  ENTRY  entries freed after launch succeeds (clears frz)
x_cancel_entry  in  ENTRY  launched entries cancelled/replayed (clears frz)
pipe0_stall  in  1  pipe0 RF stage cannot accept
pipe1_stall  in  1  pipe1 RF stage cannot accept
lch0_vld  out  1  registered pipe0 launch valid
lch0_entry  out  ENTRY  registered one-hot pipe0 entry
lch1_vld  out  1  registered pipe1 launch valid
lch1_entry  out  ENTRY  registered one-hot pipe1 entry
x_frz  out  ENTRY  frozen (in-flight) entry mask

Behaviour:
Reset values:
- age matrix = 0; x_frz = 0; lch0_vld = lch1_vld = 0; lch0_entry = lch1_entry = 0.

Age matrix:
- age[i][j] = 1 means entry i is older than entry j. Diagonal is always 0.
- On create of entry k:
  - row k is cleared;
  - age[j][k] = 1 for every j with x_entry_vld[j] = 1 and j not being created this cycle.
- Dual create in the same cycle: create0 is older than create1, so age[c0][c1] = 1 and age[c1][c0] = 0.
- A create to an entry that is still valid overwrites its age; this case is legal only after a pop.

Candidate logic:
- cand0[i] = vld[i] & lch_rdy[2i] & !frz[i]
- cand1[i] = vld[i] & lch_rdy[2i+1] & !frz[i]
- Same-cycle create entries are not candidates.

Selection:
- sel0 = the cand0 entry i such that no other cand0 entry j has age[j][i] = 1.
- sel1 = the same rule applied to (cand1 & ~sel0).
- At most one bit set per select. If there is no candidate, the select is 0.

Launch register, per pipe p:
- If rtu_flush: lchp_vld <= 0 and lchp_entry <= 0.
- Else if pipep_stall & lchp_vld: hold the register; no new selection for that pipe.
- Else: lchp_vld <= |selp and lchp_entry <= selp.
- A pipe that is stalled only suppresses its own selection.
  - Pipe0 stalled: sel0 is forced to 0, so the oldest entry is available to pipe1 if it is pipe1-ready.

Freeze:
- frz[i] sets at the clock edge where entry i is loaded into either launch register.
- frz[i] clears on x_pop_entry[i], x_cancel_entry[i], or rtu_flush.
- Clear has priority over set.
- Launch latency: ready in cycle N → lch_vld in cycle N+1 → entry excluded from selection from cycle N+1.

Boundary cases:
- All entries invalid: both launch valids are 0 next cycle.
- Single entry ready on both pipes: goes to pipe0 only.
- cpurst_b asserted mid-launch: all state returns to the reset values asynchronously.

Test Plan:
1. Creates of entries 3, 5, 1 in successive cycles; all three set pipe0-ready in the same cycle → lch0_entry = 8'b0000_1000, lch1_vld = 0; next cycle lch0_entry = 8'b0010_0000.
2. Dual create c0 = 2, c1 = 6 in the same cycle; both ready on both pipes → lch0_entry = 8'b0000_0100, lch1_entry = 8'b0100_0000, x_frz = 8'b0100_0100.
3. Pipe0 stalled with lch0_vld = 1 on entry 4 for 3 cycles → lch0_entry holds 8'b0001_0000; entry 7, ready on bit1 only, launches on pipe1 during the stall.
4. Frozen entry 2 gets x_cancel_entry[2] while still ready → x_frz[2] = 0 next cycle; entry 2 reselected the cycle after.
5. rtu_flush with both launch valids = 1 and x_frz = 8'hFF → next cycle lch0_vld = lch1_vld = 0 and x_frz = 0.
6. Reset asserted while lch1_vld = 1 → lch1_vld = 0 and the age matrix is cleared immediately; after reset deassertion the first created entry launches with 1-cycle latency.
